spi_slave: RTL and testbench

//   SPI target (slave) front end, mode 1 (CPOL=0, CPHA=1), 8-bit frames, MSB first.
//   The system clock oversamples spi_clk, cs and mosi, so all state lives in the clk domain.

---
 rtl/spi_slave.sv | 106 ++++++++++
 tb/tb_spi_slave.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI target front end, mode 1 (CPOL=0, CPHA=1), 8-bit MSB-first frames.
// All pins are oversampled in the clk domain; miso is driven on rising and mosi sampled on falling spi_clk.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       spi_clk,
  input  logic       mosi,
  input  logic [7:0] out_byte,
  output logic       miso,
  output logic [7:0] in_byte,
  output logic       finished
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       miso_q, miso_d;
  logic [7:0] in_byte_q, in_byte_d;
  logic       finished_q, finished_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Edges compare the synchronized spi_clk against one more history flop.
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_hist_d = sclk_s;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    in_byte_d   = in_byte_q;
    finished_d  = 1'b0;

    if (cs_s) begin
      // Deselected: a partial frame is dropped here, which also covers an abort.
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else if (sclk_rise) begin
      if (bit_cnt_q == 3'd0) begin
        miso_d     = out_byte[7];
        tx_shift_d = {out_byte[6:0], 1'b0};
      end else begin
        miso_d     = tx_shift_q[7];
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end else if (sclk_fall) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s};
      if (bit_cnt_q == 3'd7) begin
        in_byte_d  = {rx_shift_q[6:0], mosi_s};
        finished_d = 1'b1;
        bit_cnt_d  = 3'd0;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      miso_q      <= 1'b0;
      in_byte_q   <= 8'h00;
      finished_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      in_byte_q   <= in_byte_d;
      finished_q  <= finished_d;
    end
  end

  assign miso     = miso_q;
  assign in_byte  = in_byte_q;
  assign finished = finished_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives an SPI mode-1 master and checks received/transmitted bytes.
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       spi_clk;
  logic       mosi;
  logic [7:0] out_byte;
  logic       miso;
  logic [7:0] in_byte;
  logic       finished;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int double_pulse = 0;
  int last_fall_cyc = 0;
  logic prev_fin = 1'b0;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .spi_clk  (spi_clk),
    .mosi     (mosi),
    .out_byte (out_byte),
    .miso     (miso),
    .in_byte  (in_byte),
    .finished (finished)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // finished monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    if (finished === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_cyc = cyc;
      if (prev_fin === 1'b1) double_pulse = double_pulse + 1;
    end
    prev_fin = finished;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One master frame of nbits; out_byte switches to ob_next after the first bit.
  task automatic xfer(input logic [7:0] tx, input int nbits, input int half,
                      input logic [7:0] ob_next, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b1;
      mosi = tx[7-i];
      repeat (half) @(negedge clk);
      rx = {rx[6:0], miso};
      if (i == 0) out_byte = ob_next;
      spi_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (half) @(negedge clk);
    end
  endtask

  logic [7:0] rx;
  logic [7:0] tx_v [0:99];
  logic [7:0] ob_v [0:100];
  int p0;

  initial begin
    rst_n = 1'b0;
    cs = 1'b1;
    spi_clk = 1'b0;
    mosi = 1'b0;
    out_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_in_byte", {24'd0, in_byte}, 32'h00);
    check("rst_finished", {31'd0, finished}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single frame
    out_byte = 8'h59;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    p0 = pulse_cnt;
    xfer(8'hA5, 8, 8, 8'h59, rx);
    check("t1_in_byte", {24'd0, in_byte}, 32'hA5);
    check("t1_miso_seq", {24'd0, rx}, 32'h59);
    check("t1_pulses", pulse_cnt - p0, 32'd1);
    check("t1_latency", pulse_cyc - last_fall_cyc, 32'd3);

    // back-to-back frames, out_byte changed mid-frame
    out_byte = 8'h59;
    p0 = pulse_cnt;
    xfer(8'hFF, 8, 8, 8'h3C, rx);
    check("t2_in_byte1", {24'd0, in_byte}, 32'hFF);
    check("t2_miso1", {24'd0, rx}, 32'h59);
    check("t2_pulses1", pulse_cnt - p0, 32'd1);
    xfer(8'h00, 8, 8, 8'hE7, rx);
    check("t2_in_byte2", {24'd0, in_byte}, 32'h00);
    check("t2_miso2", {24'd0, rx}, 32'h3C);
    check("t2_pulses2", pulse_cnt - p0, 32'd2);
    cs = 1'b1;
    repeat (6) @(negedge clk);

    // abort after 3 bits, then a full frame
    out_byte = 8'hAA;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    p0 = pulse_cnt;
    xfer(8'hFF, 3, 8, 8'h96, rx);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("t3_abort_pulses", pulse_cnt - p0, 32'd0);
    check("t3_abort_in_byte", {24'd0, in_byte}, 32'h00);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    xfer(8'h81, 8, 8, 8'h96, rx);
    check("t3_in_byte", {24'd0, in_byte}, 32'h81);
    check("t3_miso", {24'd0, rx}, 32'h96);
    check("t3_pulses", pulse_cnt - p0, 32'd1);
    cs = 1'b1;
    repeat (6) @(negedge clk);

    // idle: clocks with cs high
    p0 = pulse_cnt;
    out_byte = 8'hFF;
    xfer(8'h55, 8, 8, 8'hFF, rx);
    check("t4_miso_a", {24'd0, rx}, 32'h00);
    xfer(8'hAA, 8, 8, 8'hFF, rx);
    check("t4_miso_b", {24'd0, rx}, 32'h00);
    check("t4_pulses", pulse_cnt - p0, 32'd0);
    check("t4_in_byte", {24'd0, in_byte}, 32'h81);

    // reset mid-frame
    out_byte = 8'hF0;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    xfer(8'hFF, 4, 8, 8'hC3, rx);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_rst_miso", {31'd0, miso}, 32'd0);
    check("t5_rst_in_byte", {24'd0, in_byte}, 32'h00);
    check("t5_rst_finished", {31'd0, finished}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    p0 = pulse_cnt;
    xfer(8'h5A, 8, 8, 8'hC3, rx);
    check("t5_in_byte", {24'd0, in_byte}, 32'h5A);
    check("t5_miso", {24'd0, rx}, 32'hC3);
    check("t5_pulses", pulse_cnt - p0, 32'd1);
    cs = 1'b1;
    repeat (6) @(negedge clk);

    // 100 back-to-back frames at clk = 8x spi_clk
    for (int i = 0; i < 100; i++) tx_v[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 101; i++) ob_v[i] = 8'($urandom_range(0, 255));
    out_byte = ob_v[0];
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      xfer(tx_v[i], 8, 4, ob_v[i+1], rx);
      check($sformatf("t6_in_byte_%0d", i), {24'd0, in_byte}, {24'd0, tx_v[i]});
      check($sformatf("t6_miso_%0d", i), {24'd0, rx}, {24'd0, ob_v[i]});
    end
    cs = 1'b1;
    repeat (6) @(negedge clk);

    check("double_pulse", double_pulse, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
